// File: rtl/chirp_pkg.sv
// Shared types and constants for the chirp sweep controller.
package chirp_pkg;

    localparam int unsigned SYSTEM_FREQUENCY    = 50000000;
    // 5 ms per frequency step at SYSTEM_FREQUENCY
    localparam int unsigned DWELL_TICKS_DEFAULT = 250000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        MODE_SINGLE_UP  = 2'b00,
        MODE_SAWTOOTH   = 2'b01,
        MODE_TRIANGLE   = 2'b10,
        MODE_SINGLE_TRI = 2'b11
    } mode_t;

    // Q8.8 frequency tuning word
    typedef logic [15:0] ftw_t;

    // A sweep needs a non-zero step and a strictly rising start->stop range.
    function automatic logic cfg_valid(input ftw_t f_start, input ftw_t f_stop, input ftw_t f_step);
        return (f_step != '0) && (f_start < f_stop);
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// Free-running dwell counter: counts 0..L-1 and flags the last count as a tick.
module dwell_timer #(
    parameter int unsigned L = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    output logic tick
);
    localparam int unsigned CW = (L > 1) ? $clog2(L) : 1;
    localparam logic [CW-1:0] LAST = CW'(L - 1);

    logic [CW-1:0] r_count;

    // Count up, wrap to 0 after the last count, hold at 0 while cleared.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (clear || (r_count == LAST)) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(1);
        end
    end

    assign tick = (r_count == LAST);

endmodule

// File: rtl/chirp_sweep_controller.sv
// Chirp sweep controller: steps a Q8.8 FTW between latched start/stop limits.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no sweep, ftw=0, waiting for a start with valid config
// ST_UP   | ftw rising by step each dwell, saturating at stop
// ST_DOWN | ftw falling by step each dwell, clamping at start
//
// The turn-around tick (UP at stop, DOWN at start) only changes state;
// ftw is held there for one more dwell before moving the other way.
module chirp_sweep_controller
    import chirp_pkg::*;
#(
    parameter int unsigned DWELL_TICKS = DWELL_TICKS_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        stop,
    input  logic [1:0]  mode,
    input  logic [15:0] ftw_start,
    input  logic [15:0] ftw_stop,
    input  logic [15:0] ftw_step,
    output logic [15:0] ftw,
    output logic        busy,
    output logic        step_strobe,
    output logic        sweep_done,
    output logic        cfg_err
);

    state_t r_state, w_state_nxt;
    ftw_t   r_ftw, w_ftw_nxt;
    logic   r_step_strobe, w_step_strobe_nxt;
    logic   r_sweep_done, w_sweep_done_nxt;
    logic   r_cfg_err, w_cfg_err_nxt;
    logic   w_cfg_load;

    mode_t  r_mode;
    ftw_t   r_start, r_stop, r_step;

    logic        w_tick;
    logic        w_timer_clear;
    logic [16:0] w_sum;
    logic [16:0] w_floor;
    ftw_t        w_up_ftw, w_down_ftw;

    assign w_timer_clear = (r_state == ST_IDLE) || stop;

    dwell_timer #(
        .L (DWELL_TICKS)
    ) u_dwell_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (w_timer_clear),
        .tick    (w_tick)
    );

    // Saturating 17-bit step arithmetic so neither direction can wrap.
    assign w_sum      = {1'b0, r_ftw} + {1'b0, r_step};
    assign w_floor    = {1'b0, r_start} + {1'b0, r_step};
    assign w_up_ftw   = (w_sum >= {1'b0, r_stop}) ? r_stop : w_sum[15:0];
    assign w_down_ftw = ({1'b0, r_ftw} <= w_floor) ? r_start : (r_ftw - r_step);

    // Next-state, next-ftw and pulse decode; stop overrides everything.
    always_comb begin
        w_state_nxt       = r_state;
        w_ftw_nxt         = r_ftw;
        w_step_strobe_nxt = 1'b0;
        w_sweep_done_nxt  = 1'b0;
        w_cfg_err_nxt     = 1'b0;
        w_cfg_load        = 1'b0;

        if (stop) begin
            w_state_nxt      = ST_IDLE;
            w_ftw_nxt        = '0;
            w_sweep_done_nxt = (r_state != ST_IDLE);
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_ftw_nxt = '0;
                    if (start) begin
                        if (cfg_valid(ftw_start, ftw_stop, ftw_step)) begin
                            w_cfg_load  = 1'b1;
                            w_state_nxt = ST_UP;
                            w_ftw_nxt   = ftw_start;
                        end else begin
                            w_cfg_err_nxt = 1'b1;
                        end
                    end
                end
                ST_UP: begin
                    if (w_tick) begin
                        if (r_ftw == r_stop) begin
                            case (r_mode)
                                MODE_SINGLE_UP: begin
                                    w_state_nxt      = ST_IDLE;
                                    w_ftw_nxt        = '0;
                                    w_sweep_done_nxt = 1'b1;
                                end
                                MODE_SAWTOOTH: begin
                                    w_ftw_nxt         = r_start;
                                    w_step_strobe_nxt = 1'b1;
                                end
                                default: begin
                                    w_state_nxt = ST_DOWN;
                                end
                            endcase
                        end else begin
                            w_ftw_nxt         = w_up_ftw;
                            w_step_strobe_nxt = 1'b1;
                        end
                    end
                end
                ST_DOWN: begin
                    if (w_tick) begin
                        if (r_ftw == r_start) begin
                            if (r_mode == MODE_TRIANGLE) begin
                                w_state_nxt = ST_UP;
                            end else begin
                                w_state_nxt      = ST_IDLE;
                                w_ftw_nxt        = '0;
                                w_sweep_done_nxt = 1'b1;
                            end
                        end else begin
                            w_ftw_nxt         = w_down_ftw;
                            w_step_strobe_nxt = 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_ftw_nxt   = '0;
                end
            endcase
        end
    end

    // State, ftw and single-cycle pulse registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_ftw         <= '0;
            r_step_strobe <= 1'b0;
            r_sweep_done  <= 1'b0;
            r_cfg_err     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_ftw         <= w_ftw_nxt;
            r_step_strobe <= w_step_strobe_nxt;
            r_sweep_done  <= w_sweep_done_nxt;
            r_cfg_err     <= w_cfg_err_nxt;
        end
    end

    // Sweep configuration is captured only when a start is accepted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mode  <= MODE_SINGLE_UP;
            r_start <= '0;
            r_stop  <= '0;
            r_step  <= '0;
        end else if (w_cfg_load) begin
            r_mode  <= mode_t'(mode);
            r_start <= ftw_start;
            r_stop  <= ftw_stop;
            r_step  <= ftw_step;
        end
    end

    assign ftw         = r_ftw;
    assign busy        = (r_state != ST_IDLE);
    assign step_strobe = r_step_strobe;
    assign sweep_done  = r_sweep_done;
    assign cfg_err     = r_cfg_err;

endmodule

// File: tb/tb_chirp_sweep_controller.sv
// Bench for chirp_sweep_controller: plateau-list model plus literal spot checks.
module tb_chirp_sweep_controller;

    localparam int DW = 4;
    localparam int S0 = 'h012C;
    localparam int E0 = 'h0140;
    localparam int T0 = 'h0007;

    typedef int iq_t[$];
    typedef struct {
        logic [15:0] ftw;
        logic        busy;
        logic        strobe;
        logic        done;
        logic        err;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        stop;
    logic [1:0]  mode;
    logic [15:0] ftw_start;
    logic [15:0] ftw_stop;
    logic [15:0] ftw_step;
    logic [15:0] ftw;
    logic        busy;
    logic        step_strobe;
    logic        sweep_done;
    logic        cfg_err;

    exp_t exp_q[$];
    logic exp_busy_now;
    int   n_checks;
    int   n_fail;

    chirp_sweep_controller #(
        .DWELL_TICKS (DW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .stop        (stop),
        .mode        (mode),
        .ftw_start   (ftw_start),
        .ftw_stop    (ftw_stop),
        .ftw_step    (ftw_step),
        .ftw         (ftw),
        .busy        (busy),
        .step_strobe (step_strobe),
        .sweep_done  (sweep_done),
        .cfg_err     (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Frequency plateaus a sweep visits, one entry per dwell period.
    // A turn-around dwell repeats the limit value (no frequency change).
    function automatic iq_t plateaus(input int m, input int s, input int e, input int st, input int n);
        iq_t up, dn, per, pl;
        int  v;
        v = s;
        up.push_back(v);
        while (v != e) begin
            v = (v + st > e) ? e : v + st;
            up.push_back(v);
        end
        v = e;
        while (v != s) begin
            v = (v - st < s) ? s : v - st;
            dn.push_back(v);
        end
        per = up;
        if (m >= 2) begin
            per.push_back(e);
            foreach (dn[i]) per.push_back(dn[i]);
        end
        pl = per;
        if (m == 1 || m == 2) begin
            while (pl.size() < n) begin
                foreach (per[i]) pl.push_back(per[i]);
            end
        end
        return pl;
    endfunction

    task automatic push_sweep(input int m, input int s, input int e, input int st, input int n);
        iq_t  pl;
        exp_t x;
        pl = plateaus(m, s, e, st, n);
        foreach (pl[i]) begin
            for (int k = 0; k < DW; k++) begin
                x.ftw    = 16'(pl[i]);
                x.busy   = 1'b1;
                x.strobe = (k == 0) && (i > 0) && (pl[i] != pl[(i > 0) ? i - 1 : 0]);
                x.done   = 1'b0;
                x.err    = 1'b0;
                exp_q.push_back(x);
            end
        end
        if (m == 0 || m == 3) begin
            x = '{ftw: 16'h0, busy: 1'b0, strobe: 1'b0, done: 1'b1, err: 1'b0};
            exp_q.push_back(x);
        end
    endtask

    // Per-cycle comparison against the model queue; idle when nothing queued.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else e = '{ftw: 16'h0, busy: 1'b0, strobe: 1'b0, done: 1'b0, err: 1'b0};
            exp_busy_now = e.busy;
            check("cycle {ftw,busy,strobe,done,err}",
                  {12'h0, ftw, busy, step_strobe, sweep_done, cfg_err},
                  {12'h0, e.ftw, e.busy, e.strobe, e.done, e.err});
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic do_start(input int m, input int s, input int e, input int st, input int n);
        mode      = 2'(m);
        ftw_start = 16'(s);
        ftw_stop  = 16'(e);
        ftw_step  = 16'(st);
        start     = 1'b1;
        if (!exp_busy_now) begin
            if (st != 0 && s < e) push_sweep(m, s, e, st, n);
            else exp_q.push_back('{ftw: 16'h0, busy: 1'b0, strobe: 1'b0, done: 1'b0, err: 1'b1});
        end
        cyc(1);
        start = 1'b0;
    endtask

    task automatic do_stop();
        exp_q.delete();
        exp_q.push_back('{ftw: 16'h0, busy: 1'b0, strobe: 1'b0, done: exp_busy_now, err: 1'b0});
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
    endtask

    initial begin
        iq_t pl;
        int  lit3[8];
        n_checks     = 0;
        n_fail       = 0;
        exp_busy_now = 1'b0;
        reset_n      = 1'b0;
        start        = 1'b0;
        stop         = 1'b0;
        mode         = 2'b00;
        ftw_start    = '0;
        ftw_stop     = '0;
        ftw_step     = '0;

        // Pin the model itself against the hand-derived single-triangle path.
        lit3 = '{'h012C, 'h0133, 'h013A, 'h0140, 'h0140, 'h0139, 'h0132, 'h012C};
        pl = plateaus(3, S0, E0, T0, 0);
        check("model tri size", pl.size(), 8);
        for (int i = 0; i < 8; i++) check("model tri point", pl[i], lit3[i]);

        cyc(2);
        check("reset ftw", ftw, 0);
        check("reset busy", busy, 0);
        reset_n = 1'b1;

        // Single up sweep, accepted on the first edge after reset release.
        do_start(0, S0, E0, T0, 0);
        check("up first ftw", ftw, 'h012C);
        check("up busy", busy, 1);
        cyc(4);
        check("up second ftw", ftw, 'h0133);
        check("up strobe", step_strobe, 1);
        ftw_step = 16'h0001;
        ftw_stop = 16'hFFFF;
        mode     = 2'b01;
        cyc(11);
        check("up saturated", ftw, 'h0140);
        cyc(1);
        check("up done", sweep_done, 1);
        check("up idle ftw", ftw, 0);
        cyc(2);

        // Single triangle, with a rejected-by-busy start in the middle.
        do_start(3, S0, E0, T0, 0);
        cyc(10);
        do_start(0, 'h0010, 'h0020, 'h0001, 0);
        cyc(21);
        check("tri done", sweep_done, 1);
        cyc(2);

        // Sawtooth: three full periods then abort mid-step.
        do_start(1, S0, E0, T0, 14);
        cyc(49);
        check("saw reload", ftw, 'h012C);
        cyc(1);
        do_stop();
        check("saw stop done", sweep_done, 1);
        check("saw stop ftw", ftw, 0);
        check("saw stop busy", busy, 0);
        cyc(2);

        // Repeating triangle, aborted partway down.
        do_start(2, S0, E0, T0, 12);
        cyc(30);
        do_stop();
        cyc(2);

        // Invalid configurations.
        do_start(0, S0, E0, 0, 0);
        check("zero step err", cfg_err, 1);
        cyc(1);
        do_start(0, E0, S0, T0, 0);
        check("reversed err", cfg_err, 1);
        check("reversed busy", busy, 0);
        cyc(2);

        // start and stop together in IDLE: stop wins, nothing happens.
        mode = 2'b00; ftw_start = 16'(S0); ftw_stop = 16'(E0); ftw_step = 16'(T0);
        start = 1'b1;
        stop  = 1'b1;
        cyc(1);
        start = 1'b0;
        stop  = 1'b0;
        check("start+stop busy", busy, 0);
        check("start+stop done", sweep_done, 0);
        cyc(2);

        // Asynchronous reset mid-sweep, then restart.
        do_start(0, S0, E0, T0, 0);
        cyc(6);
        #2;
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        check("async rst ftw", ftw, 0);
        check("async rst busy", busy, 0);
        check("async rst strobe", step_strobe, 0);
        check("async rst done", sweep_done, 0);
        check("async rst err", cfg_err, 0);
        cyc(2);
        reset_n = 1'b1;
        do_start(0, S0, E0, T0, 0);
        check("restart ftw", ftw, 'h012C);
        cyc(16);
        check("restart done", sweep_done, 1);
        cyc(3);

        check("model queue drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
